fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32: instruction address width.
REQ-002 Parameter DATA_W, default 32: instruction word width.
REQ-003 Parameter DEPTH, default 4: prefetch buffer entries; power of two, 2..16.
REQ-004 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-005 clk  input  1: single clock; all state updates on its rising edge.
REQ-006 rst  input  1: synchronous, active-high reset.
REQ-007 mem_req_valid  output  1: fetch request valid.
REQ-008 mem_req_ready  input  1: memory accepts the request this cycle.
REQ-009 mem_req_addr  output  ADDR_W: word-aligned fetch address.
REQ-010 mem_resp_valid  input  1: returned instruction valid; responses arrive in request order, at least 1 cycle after acceptance.
REQ-011 mem_resp_data  input  DATA_W: returned instruction.
REQ-012 inst_valid  output  1: buffered instruction available.
REQ-013 inst_ready  input  1: decode consumes the instruction.
REQ-014 inst_data  output  DATA_W: instruction at buffer head.
REQ-015 inst_pc  output  ADDR_W: address of inst_data.
REQ-016 redirect_valid  input  1: branch/jump redirect.
REQ-017 redirect_pc  input  ADDR_W: new fetch address.

Function
REQ-018 A request transfer occurs when mem_req_valid and mem_req_ready are both high; an instruction transfer occurs when inst_valid and inst_ready are both high.
REQ-019 fetch_pc advances by 4 per request transfer, modulo 2^ADDR_W (wraps to 0 after all-ones minus 3).
REQ-020 mem_req_valid is high only in RUN, when inflight + occupancy < DEPTH, and when redirect_valid is low.
REQ-021 Each response in RUN is written to the buffer together with its request address; inflight decrements on each response.
REQ-022 Buffer is FIFO; inst_valid = not empty AND NOT redirect_valid; a simultaneous write and read on a full or empty buffer is legal and preserves order.
REQ-023 FSM states: IDLE, RUN, FLUSH. IDLE -> RUN after 1 cycle. RUN -> FLUSH on redirect when inflight (after this cycle's response) > 0. RUN -> RUN on redirect with 0 inflight. FLUSH -> RUN in the cycle the last stale response arrives.
REQ-024 On redirect: buffer cleared; fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; no request or instruction transfer counts in that cycle; a response in that cycle is discarded.
REQ-025 In FLUSH, responses are discarded and no requests are issued; a redirect in FLUSH updates fetch_pc and stays in FLUSH.
REQ-026 Latency: from request acceptance with response in cycle N, inst_valid is high in cycle N+1.

Reset
REQ-027 While rst is high: state IDLE, fetch_pc = RESET_PC, buffer empty, inflight = 0, mem_req_valid = 0, inst_valid = 0; a reset mid-operation discards all buffered and in-flight instructions, and responses arriving after reset release are ignored until the first new request.

Configuration
REQ-028 Macro FETCH_PERF_EN: when defined, adds outputs perf_fetched (32 bits, counts instruction transfers) and perf_flushed (32 bits, counts discarded responses plus cleared buffer entries), both wrapping and reset to 0. When not defined, the ports and counters are absent.

Structure
REQ-029 Shared package cpu_pkg holds the fetch FSM state enum and the defaults for ADDR_W, DATA_W, and RESET_PC.
REQ-030 The buffer is sub-module fetch_fifo (parametrised width and DEPTH, with synchronous clear); fetch_unit holds the FSM, fetch_pc, and inflight counter.

Verification
REQ-031 Reset release, memory always ready, responses 1 cycle later -> addresses 0x0, 0x4, 0x8...; first inst_valid 3 cycles after reset release with inst_pc = 0x0.
REQ-032 inst_ready held low, DEPTH = 4 -> exactly 4 request transfers, then mem_req_valid stays low; a single inst transfer permits exactly 1 new request.
REQ-033 Redirect to 0x103 with 2 responses in flight -> buffer empties, FSM goes to FLUSH, 2 responses dropped, next request address 0x100, FSM returns to RUN.
REQ-034 RESET_PC = 0xFFFFFFF8 -> request addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
REQ-035 Redirect and inst_ready high in the same cycle with a full buffer -> no instruction transfer; with FETCH_PERF_EN defined, perf_flushed increases by 4.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the fetch slice.
//   fetch_state_e    : fetch FSM states (idle after reset, running, draining stale responses)
//   DEFAULT_ADDR_W   : default instruction address width
//   DEFAULT_DATA_W   : default instruction word width
//   DEFAULT_RESET_PC : default first fetch address after reset
package cpu_pkg;

    localparam int unsigned DEFAULT_ADDR_W   = 32;
    localparam int unsigned DEFAULT_DATA_W   = 32;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_FLUSH
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- memory request/response, decode and redirect signals of the fetch unit.
//   master : fetch unit side (drives mem_req_*, inst_valid/inst_data/inst_pc)
//   slave  : environment side (memory, decode, branch unit)
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
);

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
        output mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo -- prefetch buffer, DEPTH entries (power of two) of WIDTH bits.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (drops all entries)
//   wr_en    : push wr_data (accepted when not full, or when popping in the same cycle)
//   rd_en    : pop head (ignored when empty); rd_data shows the head
//   empty    : no entries; count : number of entries (0..DEPTH)
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_wr, do_rd, full;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign do_rd = rd_en && !empty;
    // A push into a full buffer is fine when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction prefetcher with in-order memory interface and redirect support.
//   clk, rst      : clock, synchronous active-high reset
//   bus (master)  : mem_req_* request channel, mem_resp_* response channel,
//                   inst_* decode channel, redirect_valid/redirect_pc
//   perf_fetched  : (FETCH_PERF_EN only) instruction transfers, wrapping
//   perf_flushed  : (FETCH_PERF_EN only) discarded responses + cleared buffer entries, wrapping
// Optional feature macro: FETCH_PERF_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned       DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
    logic [CNT_W-1:0]  inflight, inflight_next;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty, fifo_wr, fifo_clr;
    logic [ENT_W-1:0]  fifo_rd_data;
    logic              req_valid, inst_fire, resp_live, has_room;
    logic [ADDR_W-1:0] resp_pc;

    // Responses with nothing outstanding (e.g. stale ones after reset) are ignored.
    assign resp_live = bus.mem_resp_valid && (inflight != '0);
    assign has_room  = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(DEPTH);
    // In RUN all outstanding requests are consecutive words ending at fetch_pc-4,
    // so the oldest one (the one answering now) sits inflight words behind fetch_pc.
    assign resp_pc   = fetch_pc - (ADDR_W'(inflight) << 2);

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        inflight_next = inflight;
        req_valid     = 1'b0;
        fifo_wr       = 1'b0;
        fifo_clr      = 1'b0;
        if (bus.redirect_valid) begin
            fifo_clr      = 1'b1;
            fetch_pc_next = bus.redirect_pc & ~ADDR_W'(3);
            inflight_next = inflight - CNT_W'(resp_live);
            if (state == FETCH_IDLE) begin
                state_next = FETCH_RUN;
            end else begin
                state_next = (inflight_next != '0) ? FETCH_FLUSH : FETCH_RUN;
            end
        end else begin
            unique case (state)
                FETCH_IDLE: state_next = FETCH_RUN;
                FETCH_RUN: begin
                    req_valid = has_room && !rst;
                    fifo_wr   = resp_live;
                end
                FETCH_FLUSH: begin
                    if (resp_live && inflight == CNT_W'(1)) begin
                        state_next = FETCH_RUN;
                    end
                end
                default: state_next = FETCH_IDLE;
            endcase
            inflight_next = inflight + CNT_W'(req_valid && bus.mem_req_ready)
                                     - CNT_W'(resp_live);
            if (req_valid && bus.mem_req_ready) begin
                fetch_pc_next = fetch_pc + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
            inflight <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            inflight <= inflight_next;
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.inst_valid    = !fifo_empty && !bus.redirect_valid && !rst;
    assign bus.inst_pc       = fifo_rd_data[ENT_W-1:DATA_W];
    assign bus.inst_data     = fifo_rd_data[DATA_W-1:0];
    assign inst_fire         = bus.inst_valid && bus.inst_ready;

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (fifo_clr),
        .wr_en   (fifo_wr),
        .wr_data ({resp_pc, bus.mem_resp_data}),
        .rd_en   (inst_fire),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef FETCH_PERF_EN
    logic resp_drop;
    assign resp_drop = resp_live && (bus.redirect_valid || state == FETCH_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (inst_fire) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            perf_flushed <= perf_flushed + 32'(resp_drop)
                            + (fifo_clr ? 32'(fifo_count) : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] DTAG  = 32'hD000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst1;
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, perf1_fetched, perf1_flushed;
`endif

    fetch_unit #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    fetch_unit #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf1_fetched),
        .perf_flushed (perf1_flushed)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rd;
        logic        ir, redir;
        logic [31:0] rpc;
        logic        erv;
        logic [31:0] era;
        logic        eiv;
        logic [31:0] eipc;
    } vec_t;

    function automatic vec_t mk(logic r, logic rdy, logic rv, logic [31:0] rd, logic ir,
                                logic redir, logic [31:0] rpc, logic erv, logic [31:0] era,
                                logic eiv, logic [31:0] eipc);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir; v.redir = redir;
        v.rpc = rpc; v.erv = erv; v.era = era; v.eiv = eiv; v.eipc = eipc;
        return v;
    endfunction

    vec_t tbl[$];

    // ---------------- behavioural reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_FLUSH} mstate_e;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int unsigned cyc; } pend_t;

    mstate_e     m_st;
    logic [31:0] m_pc;
    logic [31:0] m_out[$];   // addresses of accepted, unanswered requests
    ent_t        m_buf[$];   // prefetch buffer contents in order
    int unsigned m_fetched, m_flushed;
    pend_t       r_q[$];     // memory side: requests waiting for a response
    int unsigned cyc = 0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    task automatic mcycle(input logic r, input logic rdy, input logic ir, input logic redir,
                          input logic [31:0] rpc, input int unsigned resp_pct);
        logic        rv, erv, eiv, req_f, inst_f;
        logic [31:0] rd;
        ent_t        e;
        rst                = r;
        bus.mem_req_ready  = rdy;
        bus.inst_ready     = ir;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        rv = 1'b0;
        rd = $urandom;
        if (!r && r_q.size() > 0 && r_q[0].cyc < cyc && $urandom_range(99) < resp_pct) begin
            rv = 1'b1;
            rd = mem_word(r_q[0].addr);
            void'(r_q.pop_front());
        end
        bus.mem_resp_valid = rv;
        bus.mem_resp_data  = rd;
        erv = !r && m_st == M_RUN && (m_out.size() + m_buf.size() < DEPTH) && !redir;
        eiv = !r && m_buf.size() > 0 && !redir;
        #4;
        check($sformatf("c%0d mem_req_valid", cyc), 32'(bus.mem_req_valid), 32'(erv));
        if (erv) check($sformatf("c%0d mem_req_addr", cyc), bus.mem_req_addr, m_pc);
        check($sformatf("c%0d inst_valid", cyc), 32'(bus.inst_valid), 32'(eiv));
        if (eiv) begin
            check($sformatf("c%0d inst_pc", cyc), bus.inst_pc, m_buf[0].pc);
            check($sformatf("c%0d inst_data", cyc), bus.inst_data, m_buf[0].data);
        end
`ifdef FETCH_PERF_EN
        check($sformatf("c%0d perf_fetched", cyc), perf_fetched, m_fetched);
        check($sformatf("c%0d perf_flushed", cyc), perf_flushed, m_flushed);
`endif
        req_f  = erv && rdy;
        inst_f = eiv && ir;
        if (req_f) r_q.push_back('{addr: m_pc, cyc: cyc});
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            m_st = M_IDLE; m_pc = 32'h0; m_out.delete(); m_buf.delete();
            m_fetched = 0; m_flushed = 0; r_q.delete();
        end else if (redir) begin
            if (rv && m_out.size() > 0) begin
                void'(m_out.pop_front());
                m_flushed++;
            end
            m_flushed += m_buf.size();
            m_buf.delete();
            m_pc = rpc & ~32'h3;
            if (m_st == M_IDLE) m_st = M_RUN;
            else m_st = (m_out.size() > 0) ? M_FLUSH : M_RUN;
        end else begin
            case (m_st)
                M_IDLE: m_st = M_RUN;
                M_RUN: begin
                    if (inst_f) begin
                        void'(m_buf.pop_front());
                        m_fetched++;
                    end
                    if (rv && m_out.size() > 0) begin
                        e.pc   = m_out.pop_front();
                        e.data = rd;
                        m_buf.push_back(e);
                    end
                    if (req_f) begin
                        m_out.push_back(m_pc);
                        m_pc = m_pc + 32'd4;
                    end
                end
                default: begin
                    if (rv && m_out.size() > 0) begin
                        void'(m_out.pop_front());
                        m_flushed++;
                        if (m_out.size() == 0) m_st = M_RUN;
                    end
                end
            endcase
        end
    endtask

    logic [31:0] wrap_exp [3];
    logic [31:0] wrap_got [$];
    logic [31:0] got_v;
    logic        rr, rdir;

    initial begin
        rst = 1'b1; rst1 = 1'b1;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus1.mem_req_ready = 1'b1; bus1.mem_resp_valid = 1'b0; bus1.mem_resp_data = '0;
        bus1.inst_ready = 1'b1; bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0;
        m_st = M_IDLE; m_pc = '0; m_fetched = 0; m_flushed = 0;

        // ---- address wrap from RESET_PC = 0xFFFFFFF8 ----
        wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0;
        repeat (2) begin @(posedge clk); #1; end
        rst1 = 1'b0;
        for (int k = 0; k < 10 && wrap_got.size() < 3; k++) begin
            #4;
            if (bus1.mem_req_valid && bus1.mem_req_ready) wrap_got.push_back(bus1.mem_req_addr);
            @(posedge clk); #1;
        end
        check("wrap request count", 32'(wrap_got.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            got_v = (k < wrap_got.size()) ? wrap_got[k] : 32'hxxxx_xxxx;
            check($sformatf("wrap addr %0d", k), got_v, wrap_exp[k]);
        end
`ifdef FETCH_PERF_EN
        check("wrap perf_fetched", perf1_fetched, 32'd0);
`endif

        // ---- directed per-cycle table ----
        tbl.push_back(mk(1,0,0,0,0,0,0,            0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,            0,0,0,0));
        tbl.push_back(mk(0,1,1,32'hDEAD_BEEF,0,0,0, 0,0,0,0));      // IDLE, stray response
        tbl.push_back(mk(0,1,0,0,0,0,0,            1,32'h0,0,0));
        tbl.push_back(mk(0,1,1,DTAG|32'h0,0,0,0,   1,32'h4,0,0));
        tbl.push_back(mk(0,1,1,DTAG|32'h4,0,0,0,   1,32'h8,1,32'h0));  // first inst_valid
        tbl.push_back(mk(0,1,1,DTAG|32'h8,0,0,0,   1,32'hC,1,32'h0));
        tbl.push_back(mk(0,1,1,DTAG|32'hC,0,0,0,   0,0,1,32'h0));      // 4 in flight/buffered
        tbl.push_back(mk(0,1,0,0,0,0,0,            0,0,1,32'h0));
        tbl.push_back(mk(0,1,0,0,0,0,0,            0,0,1,32'h0));
        tbl.push_back(mk(0,1,0,0,1,0,0,            0,0,1,32'h0));      // one inst transfer
        tbl.push_back(mk(0,1,0,0,0,0,0,            1,32'h10,1,32'h4)); // exactly one new request
        tbl.push_back(mk(0,1,0,0,0,0,0,            0,0,1,32'h4));
        tbl.push_back(mk(0,1,1,DTAG|32'h10,0,0,0,  0,0,1,32'h4));
        tbl.push_back(mk(0,1,0,0,1,0,0,            0,0,1,32'h4));
        tbl.push_back(mk(0,1,0,0,1,0,0,            1,32'h14,1,32'h8));
        tbl.push_back(mk(0,1,0,0,0,0,0,            1,32'h18,1,32'hC));
        tbl.push_back(mk(0,1,0,0,1,1,32'h103,      0,0,0,0));          // redirect, 2 in flight
        tbl.push_back(mk(0,1,1,DTAG|32'h14,0,0,0,  0,0,0,0));          // stale, dropped
        tbl.push_back(mk(0,1,1,DTAG|32'h18,0,0,0,  0,0,0,0));          // last stale, back to RUN
        tbl.push_back(mk(0,1,0,0,0,0,0,            1,32'h100,0,0));
        tbl.push_back(mk(0,0,1,DTAG|32'h100,0,0,0, 1,32'h104,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,            1,32'h104,1,32'h100));
        tbl.push_back(mk(0,0,0,0,1,0,0,            1,32'h104,0,0));
        tbl.push_back(mk(0,1,0,0,0,1,32'h200,      0,0,0,0));          // redirect, 0 in flight
        tbl.push_back(mk(0,1,0,0,0,0,0,            1,32'h200,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,            0,0,0,0));          // reset mid-operation
        tbl.push_back(mk(0,0,1,32'h1234_5678,0,0,0, 0,0,0,0));         // stale after release
        tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h0,0,0));
        tbl.push_back(mk(0,0,1,32'hCAFE_0000,0,0,0, 1,32'h0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h0,0,0));

        foreach (tbl[i]) begin
            rst                = tbl[i].rst;
            bus.mem_req_ready  = tbl[i].rdy;
            bus.mem_resp_valid = tbl[i].rv;
            bus.mem_resp_data  = tbl[i].rd;
            bus.inst_ready     = tbl[i].ir;
            bus.redirect_valid = tbl[i].redir;
            bus.redirect_pc    = tbl[i].rpc;
            #4;
            check($sformatf("row%0d mem_req_valid", i), 32'(bus.mem_req_valid), 32'(tbl[i].erv));
            if (tbl[i].erv)
                check($sformatf("row%0d mem_req_addr", i), bus.mem_req_addr, tbl[i].era);
            check($sformatf("row%0d inst_valid", i), 32'(bus.inst_valid), 32'(tbl[i].eiv));
            if (tbl[i].eiv) begin
                check($sformatf("row%0d inst_pc", i), bus.inst_pc, tbl[i].eipc);
                check($sformatf("row%0d inst_data", i), bus.inst_data, DTAG | tbl[i].eipc);
            end
            @(posedge clk); #1;
        end

        // ---- full buffer, redirect with inst_ready high ----
        mcycle(1, 0, 0, 0, 32'h0, 0);
        mcycle(1, 0, 0, 0, 32'h0, 0);
        repeat (12) mcycle(0, 1, 0, 0, 32'h0, 100);
        #4;
        check("full buffer inst_valid", 32'(bus.inst_valid), 32'd1);
        check("full buffer mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        @(posedge clk); #1;
        cyc++;
        mcycle(0, 1, 1, 1, 32'h0000_0040, 100);
`ifdef FETCH_PERF_EN
        check("redirect full perf_flushed", perf_flushed, 32'd4);
        check("redirect full perf_fetched", perf_fetched, 32'd0);
`endif
        mcycle(0, 1, 1, 0, 32'h0, 100);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            rr   = ($urandom_range(999) < 3);
            rdir = ($urandom_range(99) < 4);
            mcycle(rr, $urandom_range(99) < 75, $urandom_range(99) < 60, rdir, $urandom, 60);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
